// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: per-master request side plus the shared memory bus.
// The slave modport belongs to the arbiter; the master modport belongs to the
// environment, which drives the requests and the read data.
interface bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
);
    logic [NUM_MASTERS-1:0]        req;
    logic [NUM_MASTERS-1:0]        rd;
    logic [NUM_MASTERS-1:0]        wr;
    logic [NUM_MASTERS*ADDR_W-1:0] addr_in;
    logic [NUM_MASTERS*DATA_W-1:0] wdata_in;
    logic [NUM_MASTERS*DATA_W-1:0] rdata_out;
    logic [NUM_MASTERS-1:0]        done;
    logic [NUM_MASTERS-1:0]        grant;
    logic                          busy;
    logic [DATA_W-1:0]             data_in;
    logic                          rd_en;
    logic                          wr_en;
    logic [ADDR_W-1:0]             addr_out;
    logic [DATA_W-1:0]             data_out;

    modport master (
        output req, rd, wr, addr_in, wdata_in, data_in,
        input  rdata_out, done, grant, busy, rd_en, wr_en, addr_out, data_out
    );

    modport slave (
        input  req, rd, wr, addr_in, wdata_in, data_in,
        output rdata_out, done, grant, busy, rd_en, wr_en, addr_out, data_out
    );
endinterface

// File: rtl/bus_arbiter.sv
// Multi-master memory bus arbiter. Grants one master per access (fixed priority
// or round robin), holds the bus strobe for WAIT_STATES+1 cycles, pulses done
// and captures read data in the final cycle. Bus outputs come only from
// registered state.
module bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ARB_MODE    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   io_bus
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {StIdle, StAccess} state_e;
    typedef enum logic [1:0] {OpNull, OpRead, OpWrite} op_e;

    state_e                        r_state;
    state_e                        w_state_nxt;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              r_rr_ptr;
    logic [IDX_W-1:0]              w_win;
    op_e                           r_op;
    op_e                           w_op;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_W-1:0]             r_wdata;
    logic [CNT_W-1:0]              r_wait_cnt;
    logic [NUM_MASTERS*DATA_W-1:0] r_rdata;
    logic                          w_any;
    logic                          w_found;
    logic                          w_access;
    logic                          w_last;
    int unsigned                   w_j;

    assign w_any    = |io_bus.req;
    assign w_access = (r_state == StAccess);
    assign w_last   = w_access && (r_wait_cnt == '0);

    // Pick the winning master and decode its requested op
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_j     = 0;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!w_found && io_bus.req[i]) begin
                    w_win   = IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end else begin
            // Search starts just after the last served master, wrapping around
            for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                w_j = (int'(r_rr_ptr) + k) % NUM_MASTERS;
                if (!w_found && io_bus.req[w_j]) begin
                    w_win   = IDX_W'(w_j);
                    w_found = 1'b1;
                end
            end
        end
        // Write wins over read when both qualifiers are set
        if (io_bus.wr[w_win]) begin
            w_op = OpWrite;
        end else if (io_bus.rd[w_win]) begin
            w_op = OpRead;
        end else begin
            w_op = OpNull;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: grant from idle, return after the last wait cycle
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (w_any) w_state_nxt = StAccess;
            StAccess: if (r_wait_cnt == '0) w_state_nxt = StIdle;
        endcase
    end

    // Latch the winner's request at grant time; count down wait states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_op       <= OpNull;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
        end else if (r_state == StIdle && w_any) begin
            r_idx      <= w_win;
            r_op       <= w_op;
            r_addr     <= io_bus.addr_in[w_win*ADDR_W +: ADDR_W];
            r_wdata    <= io_bus.wdata_in[w_win*DATA_W +: DATA_W];
            r_wait_cnt <= CNT_W'(WAIT_STATES);
        end else if (w_access && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Completion: capture read data and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rr_ptr <= IDX_W'(NUM_MASTERS - 1);
        end else if (w_last) begin
            r_rr_ptr <= r_idx;
            if (r_op == OpRead) begin
                r_rdata[r_idx*DATA_W +: DATA_W] <= io_bus.data_in;
            end
        end
    end

    assign io_bus.grant     = w_access ? (NUM_MASTERS'(1) << r_idx) : '0;
    assign io_bus.done      = w_last ? (NUM_MASTERS'(1) << r_idx) : '0;
    assign io_bus.busy      = w_access;
    assign io_bus.rd_en     = w_access && (r_op == OpRead);
    assign io_bus.wr_en     = w_access && (r_op == OpWrite);
    assign io_bus.addr_out  = r_addr;
    assign io_bus.data_out  = r_wdata;
    assign io_bus.rdata_out = r_rdata;

endmodule
